multi_channel_clock_divider: RTL and testbench

MULTI_CHANNEL_CLOCK_DIVIDER -- requirements
Module: multi_channel_clock_divider

---
 rtl/multi_channel_clock_divider.sv | 96 +++++++++
 tb/tb_multi_channel_clock_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_clock_divider.sv
// Bank of independent integer clock dividers with glitch-free divisor updates.
// Optional phase realign on sync_start when CLKDIV_SYNC_START_EN is defined.
module multi_channel_clock_divider #(
  parameter int NUM_CHANNELS = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int DEFAULT_DIV  = 4,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk_FPGA,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [DIV_WIDTH-1:0]    wr_div,
  input  logic                    sync_start,
  output logic [NUM_CHANNELS-1:0] clock_signal,
  output logic [NUM_CHANNELS-1:0] period_tick,
  output logic [NUM_CHANNELS-1:0] update_pending
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEFAULT_DIV);

  // High phase length ceil(n/2), one bit wider so n = all-ones cannot overflow.
  function automatic logic [DIV_WIDTH:0] hi_thresh(input logic [DIV_WIDTH-1:0] n);
    logic [DIV_WIDTH:0] t;
    t = {1'b0, n} + {{DIV_WIDTH{1'b0}}, 1'b1};
    return t >> 1;
  endfunction

  logic wr_ok;
  logic sync;

  assign wr_ok = (32'(wr_ch) < NUM_CHANNELS);

`ifdef CLKDIV_SYNC_START_EN
  assign sync = sync_start;
`else
  logic unused_sync;
  assign unused_sync = sync_start;
  assign sync        = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] cnt_p0;
    logic [DIV_WIDTH-1:0] div_p0;
    logic [DIV_WIDTH-1:0] pdiv_p0;
    logic                 pend_p0;
    logic                 clk_p1;
    logic                 active;
    logic                 wrap;
    logic                 wr_hit;
    logic                 apply;

    assign active = (div_p0 >= TWO);
    assign wrap   = enable && active && (cnt_p0 == div_p0 - ONE);
    assign wr_hit = wr_en && wr_ok && (wr_ch == CH_W'(i));
    // A pending divisor lands only where no period is in flight.
    assign apply  = pend_p0 && (sync || !active || wrap);

    // Stage 0: divisor bookkeeping and period counter; stage 1: registered clock
    always_ff @(posedge clk_FPGA or negedge reset) begin
      if (!reset) begin
        cnt_p0  <= '0;
        div_p0  <= DEF;
        pend_p0 <= 1'b0;
        clk_p1  <= 1'b0;
      end else begin
        if (apply)
          div_p0 <= pdiv_p0;
        if (wr_hit)
          pend_p0 <= 1'b1;
        else if (apply)
          pend_p0 <= 1'b0;
        if (sync || !active) begin
          cnt_p0 <= '0;
          clk_p1 <= 1'b0;
        end else if (enable) begin
          cnt_p0 <= wrap ? '0 : cnt_p0 + ONE;
          clk_p1 <= ({1'b0, cnt_p0} < hi_thresh(div_p0));
        end
      end
    end

    always_ff @(posedge clk_FPGA) begin
      if (wr_hit)
        pdiv_p0 <= wr_div;
    end

    assign clock_signal[i]   = clk_p1;
    assign period_tick[i]    = wrap;
    assign update_pending[i] = pend_p0;
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed bench for multi_channel_clock_divider (3 channels so wr_ch can go out of range).
module tb_multi_channel_clock_divider;

  localparam int NCH = 3;
  localparam int DW  = 8;

  logic           clk_FPGA = 1'b0;
  logic           reset;
  logic           enable;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [DW-1:0]  wr_div;
  logic           sync_start;
  logic [NCH-1:0] clock_signal;
  logic [NCH-1:0] period_tick;
  logic [NCH-1:0] update_pending;

  int n_tests = 0;
  int n_fail  = 0;

  multi_channel_clock_divider #(
    .NUM_CHANNELS(NCH),
    .DIV_WIDTH   (DW),
    .DEFAULT_DIV (4)
  ) dut (
    .clk_FPGA      (clk_FPGA),
    .reset         (reset),
    .enable        (enable),
    .wr_en         (wr_en),
    .wr_ch         (wr_ch),
    .wr_div        (wr_div),
    .sync_start    (sync_start),
    .clock_signal  (clock_signal),
    .period_tick   (period_tick),
    .update_pending(update_pending)
  );

  always #5 clk_FPGA = ~clk_FPGA;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One rising edge, then land on the falling edge where outputs are sampled
  task automatic step();
    @(posedge clk_FPGA);
    @(negedge clk_FPGA);
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync_start = 1'b0;
    @(negedge clk_FPGA);
    reset = 1'b1;
  endtask

  task automatic write(input logic [1:0] ch, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_div = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pa_clk;
    logic [7:0] pa_tick;
    logic [4:0] pb_clk;
    logic [4:0] pb_tick;
    logic [5:0] pc_clk;
    logic [5:0] pc_tick;
    logic [3:0] pe_clk;
    logic [3:0] pe_tick;

    // Reset state, held with enable high
    reset = 1'b0; enable = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync_start = 1'b0;
    @(negedge clk_FPGA);
    @(negedge clk_FPGA);
    check("rst_clk",  32'(clock_signal),   32'h0);
    check("rst_tick", 32'(period_tick),    32'h0);
    check("rst_pend", 32'(update_pending), 32'h0);

    // Default N=4 after reset: 1,1,0,0 and a tick on the 4th count
    reset = 1'b1;
    pa_clk  = 8'b11001100;
    pa_tick = 8'b00100010;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("a_clk%0d", k + 1),  32'(clock_signal), pa_clk[7-k]  ? 32'h7 : 32'h0);
      check($sformatf("a_tick%0d", k + 1), 32'(period_tick),  pa_tick[7-k] ? 32'h7 : 32'h0);
    end
    check("a_pend", 32'(update_pending), 32'h0);

    // ch1 N=5 written mid-period: old period completes, then 3 high / 2 low
    do_reset();
    step();
    write(2'd1, 8'd5);
    check("b_pend_e2", 32'(update_pending[1]), 32'h1);
    step();
    check("b_pend_e3", 32'(update_pending[1]), 32'h1);
    check("b_tick_e3", 32'(period_tick[1]),    32'h1);
    step();
    check("b_pend_e4", 32'(update_pending[1]), 32'h0);
    check("b_clk_e4",  32'(clock_signal[1]),   32'h0);
    pb_clk  = 5'b11100;
    pb_tick = 5'b00010;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("b_clk_e%0d", k + 5),  32'(clock_signal[1]), 32'(pb_clk[4-k]));
      check($sformatf("b_tick_e%0d", k + 5), 32'(period_tick[1]),  32'(pb_tick[4-k]));
    end

    // ch2: N=1 disables it, then N=6 applies on the following edge
    do_reset();
    write(2'd2, 8'd1);
    for (int k = 0; k < 3; k++) step();
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("c_off_clk%0d", k), 32'(clock_signal[2]), 32'h0);
      check($sformatf("c_off_tick%0d", k), 32'(period_tick[2]), 32'h0);
    end
    write(2'd2, 8'd6);
    check("c_pend_e8", 32'(update_pending[2]), 32'h1);
    check("c_clk_e8",  32'(clock_signal[2]),   32'h0);
    step();
    check("c_pend_e9", 32'(update_pending[2]), 32'h0);
    check("c_clk_e9",  32'(clock_signal[2]),   32'h0);
    pc_clk  = 6'b111000;
    pc_tick = 6'b000010;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("c_clk_e%0d", k + 10),  32'(clock_signal[2]), 32'(pc_clk[5-k]));
      check($sformatf("c_tick_e%0d", k + 10), 32'(period_tick[2]),  32'(pc_tick[5-k]));
    end

    // Freeze for 5 edges mid-high-phase, write during freeze, resume in phase
    do_reset();
    step();
    step();
    enable = 1'b0;
    step();
    check("d_clk_e3",  32'(clock_signal), 32'h7);
    check("d_tick_e3", 32'(period_tick),  32'h0);
    write(2'd1, 8'd2);
    check("d_pend_e4", 32'(update_pending), 32'h2);
    step(); step(); step();
    check("d_clk_e7",  32'(clock_signal),   32'h7);
    check("d_pend_e7", 32'(update_pending), 32'h2);
    enable = 1'b1;
    step();
    check("d_clk_e8",  32'(clock_signal),   32'h0);
    check("d_tick_e8", 32'(period_tick),    32'h7);
    check("d_pend_e8", 32'(update_pending), 32'h2);
    step();
    check("d_clk_e9",  32'(clock_signal),   32'h0);
    check("d_pend_e9", 32'(update_pending), 32'h0);
    step();
    check("d_clk_e10",  32'(clock_signal), 32'h7);
    check("d_tick_e10", 32'(period_tick),  32'h2);
    step();
    check("d_clk_e11",  32'(clock_signal), 32'h5);
    check("d_tick_e11", 32'(period_tick),  32'h0);

    // Write on the wrap edge lands one period later; out-of-range write is ignored
    do_reset();
    step(); step(); step();
    write(2'd0, 8'd3);
    check("e_pend_e4", 32'(update_pending), 32'h1);
    check("e_clk_e4",  32'(clock_signal),   32'h0);
    write(2'd3, 8'd2);
    check("e_pend_e5", 32'(update_pending), 32'h1);
    step(); step();
    check("e_tick_e7", 32'(period_tick), 32'h7);
    step();
    check("e_pend_e8", 32'(update_pending), 32'h0);
    pe_clk  = 4'b1101;
    pe_tick = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("e_clk_e%0d", k + 9),  32'(clock_signal[0]), 32'(pe_clk[3-k]));
      check($sformatf("e_tick_e%0d", k + 9), 32'(period_tick[0]),  32'(pe_tick[3-k]));
      if (k == 2)
        check("e_oth_tick_e11", 32'(period_tick[2:1]), 32'h3);
    end

`ifdef CLKDIV_SYNC_START_EN
    // ch0 N=3 and ch1 N=4 out of phase, then realigned by sync_start
    do_reset();
    write(2'd0, 8'd3);
    for (int k = 0; k < 6; k++) step();
    check("f_tick_e7", 32'(period_tick), 32'h6);
    sync_start = 1'b1;
    write(2'd2, 8'd2);
    sync_start = 1'b0;
    check("f_clk_e8",  32'(clock_signal),   32'h0);
    check("f_pend_e8", 32'(update_pending), 32'h4);
    step();
    check("f_clk_e9", 32'(clock_signal[1:0]), 32'h3);
    step(); step(); step();
    check("f_clk_e12", 32'(clock_signal[1:0]), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
